// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: word size, ALU op codes,
// response-buffer state encoding and the op-code legality helper.
package alu_req_arbiter_pkg;

  localparam int ALU_WORDSIZE = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  function automatic logic alu_op_legal(input logic [3:0] ctl);
    return (ctl == ALU_AND) || (ctl == ALU_OR) || (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_alu.sv
// Shared combinational ALU: AND/OR/ADD/SUB, wrap-around arithmetic, zero flag.
// Unrecognised op codes produce a zero result.
module alu_req_arbiter_alu
  import alu_req_arbiter_pkg::*;
#(
  parameter int WORDSIZE = ALU_WORDSIZE
) (
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [3:0]          ctl,
  output logic [WORDSIZE-1:0] result,
  output logic                zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters; result lands in a
// single-entry response buffer 1 cycle after accept. ALU_OPCHK_EN flags illegal op codes.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int WORDSIZE = ALU_WORDSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WORDSIZE-1:0] req0_a,
  input  logic [WORDSIZE-1:0] req0_b,
  input  logic [3:0]          req0_ctl,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WORDSIZE-1:0] req1_a,
  input  logic [WORDSIZE-1:0] req1_b,
  input  logic [3:0]          req1_ctl,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WORDSIZE-1:0] rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err
);

  rsp_state_t          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                rsp_id_q, rsp_id_d;
  logic [WORDSIZE-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;

  logic                grant;
  logic                can_accept;
  logic                accept;
  logic                op_err;
  logic [WORDSIZE-1:0] alu_in1, alu_in2, alu_result;
  logic [3:0]          alu_ctl;
  logic                alu_zero;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Draining the buffer in the same cycle frees it for a new accept.
  assign can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
  assign req0_ready = can_accept && !grant;
  assign req1_ready = can_accept && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign alu_in1 = grant ? req1_a   : req0_a;
  assign alu_in2 = grant ? req1_b   : req0_b;
  assign alu_ctl = grant ? req1_ctl : req0_ctl;

  alu_req_arbiter_alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .in1    (alu_in1),
    .in2    (alu_in2),
    .ctl    (alu_ctl),
    .result (alu_result),
    .zero   (alu_zero)
  );

`ifdef ALU_OPCHK_EN
  assign op_err = !alu_op_legal(alu_ctl);
`else
  assign op_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept)         state_d = FULL;
    else if (rsp_ready) state_d = EMPTY;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    if (accept) begin
      last_grant_d = grant;
      rsp_id_d     = grant;
      rsp_err_d    = op_err;
      rsp_result_d = op_err ? '0 : alu_result;
      rsp_zero_d   = op_err | alu_zero;
    end
  end

  always_comb begin
    rsp_valid  = (state_q == FULL);
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_zero   = rsp_zero_q;
    rsp_err    = rsp_err_q;
  end

endmodule
